// File: rtl/calc_core.sv
// calc_core: arithmetic stage of the 8-bit calculator.
// Holds two signed operands loaded from the switch bank. On GO it runs
// ADD/SUB in one edge, or MUL/DIV over N iterative steps plus one FIX
// (sign/overflow) edge. All outputs come straight from registers.
module calc_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] SW,
    input  logic [1:0]   OP,
    input  logic         LOAD_A,
    input  logic         LOAD_B,
    input  logic         GO,
    output logic [N-1:0] X,
    output logic         BUSY,
    output logic         DONE,
    output logic         OVF,
    output logic         DIV0
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Largest product/quotient magnitudes that still fit a signed N-bit result.
    localparam logic [2*N-1:0] POS_LIM = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [2*N-1:0] NEG_LIM = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    // Magnitude of a two's-complement value; N+1 bits so -2^(N-1) is exact.
    function automatic logic [N:0] mag_of(input logic [N-1:0] v);
        logic [N:0] ext;
        ext = {v[N-1], v};
        if (v[N-1]) begin
            mag_of = (~ext) + {{N{1'b0}}, 1'b1};
        end else begin
            mag_of = ext;
        end
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   x_q, x_d;
    logic           ovf_q, ovf_d;
    logic           div0_q, div0_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           sign_q, sign_d;
    logic           is_div_q, is_div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N:0]     mplier_q, mplier_d;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [N:0]     dvs_q, dvs_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;

    logic [N-1:0]   sum_s;
    logic [N-1:0]   diff_s;
    logic [N:0]     mag_a_s;
    logic [N:0]     mag_b_s;
    logic [N:0]     trial_s;
    logic [N:0]     trial_sub_s;
    logic [2*N-1:0] res_mag_s;
    logic [N-1:0]   res_low_s;

    // Next-state, datapath and output decode for the IDLE/MUL/DIV/FIX sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        sign_d   = sign_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;

        sum_s       = a_q + b_q;
        diff_s      = a_q - b_q;
        mag_a_s     = mag_of(a_q);
        mag_b_s     = mag_of(b_q);
        trial_s     = {rem_q, dvd_q[N-1]};
        trial_sub_s = trial_s - dvs_q;
        res_mag_s   = is_div_q ? {{N{1'b0}}, quo_q} : acc_q;
        res_low_s   = sign_q ? ((~res_mag_s[N-1:0]) + {{(N-1){1'b0}}, 1'b1})
                             : res_mag_s[N-1:0];

        case (state_q)
            S_IDLE: begin
                // GO below reads a_q/b_q, so a same-cycle load only affects later ops.
                a_d = LOAD_A ? SW : a_q;
                b_d = LOAD_B ? SW : b_q;
                if (GO) begin
                    case (OP)
                        OP_ADD: begin
                            x_d    = sum_s;
                            ovf_d  = (a_q[N-1] == b_q[N-1]) && (sum_s[N-1] != a_q[N-1]);
                            div0_d = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_SUB: begin
                            x_d    = diff_s;
                            ovf_d  = (a_q[N-1] != b_q[N-1]) && (diff_s[N-1] != a_q[N-1]);
                            div0_d = 1'b0;
                            done_d = 1'b1;
                        end
                        OP_MUL: begin
                            mcand_d  = {{(N-1){1'b0}}, mag_a_s};
                            mplier_d = mag_b_s;
                            acc_d    = {(2*N){1'b0}};
                            cnt_d    = {CW{1'b0}};
                            sign_d   = a_q[N-1] ^ b_q[N-1];
                            is_div_d = 1'b0;
                            busy_d   = 1'b1;
                            state_d  = S_MUL;
                        end
                        OP_DIV: begin
                            if (b_q == {N{1'b0}}) begin
                                x_d    = {N{1'b0}};
                                ovf_d  = 1'b0;
                                div0_d = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                dvd_d    = mag_a_s[N-1:0];
                                dvs_d    = mag_b_s;
                                rem_d    = {N{1'b0}};
                                quo_d    = {N{1'b0}};
                                cnt_d    = {CW{1'b0}};
                                sign_d   = a_q[N-1] ^ b_q[N-1];
                                is_div_d = 1'b1;
                                busy_d   = 1'b1;
                                state_d  = S_DIV;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = {mcand_q[2*N-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[N:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DIV: begin
                dvd_d = {dvd_q[N-2:0], 1'b0};
                // Remainder stays below the divisor (<= 2^(N-1)), so N bits hold it.
                if (trial_s >= dvs_q) begin
                    rem_d = trial_sub_s[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = trial_s[N-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FIX: begin
                // Overflow covers both 12*-11 style products and -2^(N-1) / -1.
                x_d     = res_low_s;
                ovf_d   = sign_q ? (res_mag_s > NEG_LIM) : (res_mag_s > POS_LIM);
                div0_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, iteration and result/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= {N{1'b0}};
            b_q      <= {N{1'b0}};
            x_q      <= {N{1'b0}};
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sign_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {(2*N){1'b0}};
            mcand_q  <= {(2*N){1'b0}};
            mplier_q <= {(N+1){1'b0}};
            dvd_q    <= {N{1'b0}};
            dvs_q    <= {(N+1){1'b0}};
            rem_q    <= {N{1'b0}};
            quo_q    <= {N{1'b0}};
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            sign_q   <= sign_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

    assign X    = x_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OVF  = ovf_q;
    assign DIV0 = div0_q;

endmodule
